// File: rtl/imm_extend_pipe.sv
// Pipelined immediate-extension unit: sign/zero/upper/sign+shift extension
// behind a registered valid/ready stage with a 2-entry skid buffer.
//
// state | meaning
// EMPTY | nothing held; OUT invalid, ready to accept
// BUSY  | OUT holds a beat, SKID empty; still ready to accept
// FULL  | OUT and SKID both hold beats; not ready
module imm_extend_pipe #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int SHL   = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [IN_W-1:0]  data_i,
   input  logic [1:0]       mode_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [OUT_W-1:0] data_o,
   output logic [1:0]       mode_o
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           state;
   logic [OUT_W-1:0] sext;
   logic [OUT_W-1:0] ext;
   logic [OUT_W-1:0] skid_data;
   logic [1:0]       skid_mode;
   logic             accept;
   logic             consume;

   always_comb begin
      sext = {{(OUT_W-IN_W){data_i[IN_W-1]}}, data_i};
      case (mode_i)
         2'd0:    ext = sext;
         2'd1:    ext = {{(OUT_W-IN_W){1'b0}}, data_i};
         2'd2:    ext = {data_i, {(OUT_W-IN_W){1'b0}}};
         default: ext = sext << SHL;
      endcase
   end

   assign accept  = valid_i && ready_o;
   assign consume = valid_o && ready_i;

   // ready_o is registered so there is no combinational path from ready_i
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= EMPTY;
         valid_o   <= 1'b0;
         ready_o   <= 1'b1;
         data_o    <= '0;
         mode_o    <= 2'd0;
         skid_data <= '0;
         skid_mode <= 2'd0;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  data_o  <= ext;
                  mode_o  <= mode_i;
                  valid_o <= 1'b1;
                  state   <= BUSY;
               end
            end
            BUSY: begin
               if (accept && consume) begin
                  data_o <= ext;
                  mode_o <= mode_i;
               end else if (consume) begin
                  valid_o <= 1'b0;
                  state   <= EMPTY;
               end else if (accept) begin
                  skid_data <= ext;
                  skid_mode <= mode_i;
                  ready_o   <= 1'b0;
                  state     <= FULL;
               end
            end
            FULL: begin
               if (consume) begin
                  data_o  <= skid_data;
                  mode_o  <= skid_mode;
                  ready_o <= 1'b1;
                  state   <= BUSY;
               end
            end
            default: begin
               valid_o <= 1'b0;
               ready_o <= 1'b1;
               state   <= EMPTY;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe with a queue scoreboard on the output stream.
module tb_imm_extend_pipe;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        valid_i, ready_i, ready_o, valid_o;
   logic [15:0] data_i;
   logic [1:0]  mode_i, mode_o;
   logic [31:0] data_o;

   logic        valid2_i, ready2_i, ready2_o, valid2_o;
   logic [11:0] data2_i;
   logic [1:0]  mode2_i, mode2_o;
   logic [19:0] data2_o;

   logic [31:0] exp_q[$];
   logic [1:0]  expm_q[$];
   int          checks = 0;
   int          failed = 0;

   always #5 clk_i = ~clk_i;

   imm_extend_pipe #(.IN_W(16), .OUT_W(32), .SHL(2)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
      .data_i(data_i), .mode_i(mode_i), .valid_o(valid_o), .ready_i(ready_i),
      .data_o(data_o), .mode_o(mode_o)
   );

   imm_extend_pipe #(.IN_W(12), .OUT_W(20), .SHL(1)) dut2 (
      .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid2_i), .ready_o(ready2_o),
      .data_i(data2_i), .mode_i(mode2_i), .valid_o(valid2_o), .ready_i(ready2_i),
      .data_o(data2_o), .mode_o(mode2_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failed++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
      end
   endtask

   // Drive one cycle; scoreboard pops on consume and pushes on accept.
   task automatic step(input logic v, input logic [15:0] d, input logic [1:0] m,
                       input logic [31:0] e, input logic rdy);
      logic [31:0] ed;
      logic [1:0]  em;
      valid_i = v; data_i = d; mode_i = m; ready_i = rdy;
      @(negedge clk_i);
      if (!rst_i && valid_o && ready_i) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_beat", data_o, 32'hDEAD_BEEF);
         end else begin
            ed = exp_q.pop_front();
            em = expm_q.pop_front();
            chk("sb_data", data_o, ed);
            chk("sb_mode", {30'd0, mode_o}, {30'd0, em});
         end
      end
      if (!rst_i && valid_i && ready_o) begin
         exp_q.push_back(e);
         expm_q.push_back(m);
      end
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      rst_i = 1'b1;
      valid_i = 0; ready_i = 1; data_i = '0; mode_i = 0;
      valid2_i = 0; ready2_i = 1; data2_i = '0; mode2_i = 0;
      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      chk("rst_valid", {31'd0, valid_o}, 32'd0);
      chk("rst_ready", {31'd0, ready_o}, 32'd1);
      chk("rst_data", data_o, 32'd0);
      chk("rst_mode", {30'd0, mode_o}, 32'd0);

      // all four modes on 0x8001
      step(1, 16'h8001, 2'd0, 32'hFFFF8001, 1);
      chk("lat_valid", {31'd0, valid_o}, 32'd1);
      chk("lat_data", data_o, 32'hFFFF8001);
      step(1, 16'h8001, 2'd1, 32'h00008001, 1);
      step(1, 16'h8001, 2'd2, 32'h80010000, 1);
      step(1, 16'h8001, 2'd3, 32'hFFFE0004, 1);
      // positive / edge values
      step(1, 16'h0004, 2'd3, 32'h00000010, 1);
      step(1, 16'hFFFF, 2'd3, 32'hFFFFFFFC, 1);
      step(1, 16'h7FFF, 2'd0, 32'h00007FFF, 1);
      step(0, 16'h0, 2'd0, 32'h0, 1);
      chk("idle_valid", {31'd0, valid_o}, 32'd0);

      // streaming at full throughput
      for (int i = 0; i < 8; i++) begin
         step(1, 16'(i), 2'd0, 32'(i), 1);
         chk("stream_valid", {31'd0, valid_o}, 32'd1);
         chk("stream_ready", {31'd0, ready_o}, 32'd1);
      end
      step(0, 16'h0, 2'd0, 32'h0, 1);
      chk("stream_end_valid", {31'd0, valid_o}, 32'd0);

      // backpressure into the skid buffer
      step(1, 16'h1111, 2'd0, 32'h00001111, 0);
      chk("bp_ready_after_a", {31'd0, ready_o}, 32'd1);
      step(1, 16'h2222, 2'd0, 32'h00002222, 0);
      chk("bp_ready_full", {31'd0, ready_o}, 32'd0);
      chk("bp_hold_a", data_o, 32'h00001111);
      step(1, 16'h3333, 2'd1, 32'h00003333, 0);
      chk("bp_ignored_ready", {31'd0, ready_o}, 32'd0);
      chk("bp_still_a", data_o, 32'h00001111);
      step(0, 16'h0, 2'd0, 32'h0, 1);
      chk("bp_ready_after_consume", {31'd0, ready_o}, 32'd1);
      chk("bp_b_out", data_o, 32'h00002222);
      step(0, 16'h0, 2'd0, 32'h0, 1);
      chk("bp_drained_valid", {31'd0, valid_o}, 32'd0);

      // reset while FULL
      step(1, 16'hAAAA, 2'd0, 32'hFFFFAAAA, 0);
      step(1, 16'hBBBB, 2'd0, 32'hFFFFBBBB, 0);
      chk("pre_rst_full", {31'd0, ready_o}, 32'd0);
      rst_i = 1'b1;
      step(1, 16'hCCCC, 2'd1, 32'h0000CCCC, 0);
      rst_i = 1'b0;
      exp_q.delete();
      expm_q.delete();
      chk("mid_rst_valid", {31'd0, valid_o}, 32'd0);
      chk("mid_rst_ready", {31'd0, ready_o}, 32'd1);
      chk("mid_rst_data", data_o, 32'd0);
      step(1, 16'h0005, 2'd1, 32'h00000005, 1);
      chk("post_rst_data", data_o, 32'h00000005);
      step(0, 16'h0, 2'd0, 32'h0, 1);
      chk("post_rst_empty", {31'd0, valid_o}, 32'd0);

      // parameter sweep instance
      valid2_i = 1; data2_i = 12'h800; mode2_i = 2'd3; ready2_i = 1;
      @(posedge clk_i);
      #1;
      chk("p2_m3_valid", {31'd0, valid2_o}, 32'd1);
      chk("p2_m3_data", {12'd0, data2_o}, 32'h000FF000);
      chk("p2_m3_mode", {30'd0, mode2_o}, 32'd3);
      mode2_i = 2'd2;
      @(posedge clk_i);
      #1;
      valid2_i = 0;
      chk("p2_m2_data", {12'd0, data2_o}, 32'h00080000);
      chk("p2_m2_mode", {30'd0, mode2_o}, 32'd2);

      // drain any remaining expected beats within a bounded window
      for (int k = 0; k < 20 && exp_q.size() != 0; k++)
         step(0, 16'h0, 2'd0, 32'h0, 1);
      chk("sb_empty", exp_q.size(), 32'd0);

      $display("%0d/%0d checks passed", checks - failed, checks);
      $finish;
   end

endmodule
